// File: rtl/bus_pkg.sv
// Shared types and widths for the system bus arbiter.
//   arb_state_t  arbiter FSM state (IDLE, BUSY)
//   BUS_ADDR_W   default bus address width
//   BUS_DATA_W   default bus data width
package bus_pkg;

   typedef enum logic {IDLE, BUSY} arb_state_t;

   localparam int BUS_ADDR_W = 16;
   localparam int BUS_DATA_W = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: returns the first requester at or after ptr, wrapping.
// Ports:
//   req      in   N     request vector
//   ptr      in   IDW   round-robin start index (always < N)
//   gnt_idx  out  IDW   index of the winning requester (0 when none)
//   any_req  out  1     at least one request is set
module rr_arbiter
   import bus_pkg::*;
#(
   parameter int N   = 3,
   parameter int IDW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]   req,
   input  logic [IDW-1:0] ptr,
   output logic [IDW-1:0] gnt_idx,
   output logic           any_req
);

   int idx;

   always_comb begin
      gnt_idx = '0;
      any_req = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) begin
            idx = idx - N;
         end
         if (!any_req && req[idx]) begin
            any_req = 1'b1;
            gnt_idx = IDW'(idx);
         end
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Central round-robin arbiter and master-side mux for the shared system bus.
// Ports:
//   clk, rst       clock (rising edge), asynchronous active-high reset
//   m_breq         per-master bus request
//   m_bgrant       one-hot grant (zero when idle)
//   m_addr/m_wdata packed per-master address / write data, master i at [i*W +: W]
//   m_mode/m_valid per-master mode (1=write) and transaction valid
//   m_sl_valid     slave valid returned to the granted master only
//   m_rdata        read data broadcast to all masters
//   bus_*          muxed slave-side bus; all zero while idle
//   bus_rdata, bus_sl_valid  slave response
//   grant_id       index of current owner (0 when idle)
//   busy           a grant is active
//   timeout_err    one-cycle pulse when the watchdog reclaims the bus
module bus_arbiter
   import bus_pkg::*;
#(
   parameter int NUM_MASTERS = 3,
   parameter int ADDR_W      = BUS_ADDR_W,
   parameter int DATA_W      = BUS_DATA_W,
   parameter int TIMEOUT     = 255,
   localparam int IDW        = $clog2(NUM_MASTERS),
   localparam int WDW        = $clog2(TIMEOUT + 1)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_MASTERS-1:0]        m_breq,
   output logic [NUM_MASTERS-1:0]        m_bgrant,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata,
   input  logic [NUM_MASTERS-1:0]        m_mode,
   input  logic [NUM_MASTERS-1:0]        m_valid,
   output logic [NUM_MASTERS-1:0]        m_sl_valid,
   output logic [DATA_W-1:0]             m_rdata,
   output logic [ADDR_W-1:0]             bus_addr,
   output logic [DATA_W-1:0]             bus_wdata,
   output logic                          bus_mode,
   output logic                          bus_mvalid,
   input  logic [DATA_W-1:0]             bus_rdata,
   input  logic                          bus_sl_valid,
   output logic [IDW-1:0]                grant_id,
   output logic                          busy,
   output logic                          timeout_err
);

   arb_state_t             state_q, state_d;
   logic [NUM_MASTERS-1:0] grant_q, grant_d;
   logic [IDW-1:0]         gid_q, gid_d;
   logic [IDW-1:0]         ptr_q, ptr_d;
   logic [WDW-1:0]         wd_q, wd_d;
   logic                   terr_q, terr_d;

   logic [IDW-1:0]         win_idx;
   logic                   any_req;
   logic [IDW-1:0]         ptr_after_owner;

   rr_arbiter #(
      .N   (NUM_MASTERS),
      .IDW (IDW)
   ) u_rr (
      .req     (m_breq),
      .ptr     (ptr_q),
      .gnt_idx (win_idx),
      .any_req (any_req)
   );

   assign ptr_after_owner = (gid_q == IDW'(NUM_MASTERS - 1)) ? '0 : gid_q + IDW'(1);

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gid_d   = gid_q;
      ptr_d   = ptr_q;
      wd_d    = wd_q;
      terr_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            // Stray bus_sl_valid is ignored here; the watchdog only runs in BUSY.
            if (any_req) begin
               state_d = BUSY;
               gid_d   = win_idx;
               grant_d = NUM_MASTERS'(1) << win_idx;
               wd_d    = '0;
            end
         end
         BUSY: begin
            if (!m_breq[gid_q]) begin
               state_d = IDLE;
               grant_d = '0;
               gid_d   = '0;
               ptr_d   = ptr_after_owner;
               wd_d    = '0;
            end else if (bus_sl_valid) begin
               wd_d = '0;
            end else if (int'(wd_q) + 1 >= TIMEOUT) begin
               // Forced release behaves exactly like a voluntary one, plus the error pulse.
               state_d = IDLE;
               grant_d = '0;
               gid_d   = '0;
               ptr_d   = ptr_after_owner;
               wd_d    = '0;
               terr_d  = 1'b1;
            end else begin
               wd_d = wd_q + WDW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            grant_d = '0;
            gid_d   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         grant_q <= '0;
         gid_q   <= '0;
         ptr_q   <= '0;
         wd_q    <= '0;
         terr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gid_q   <= gid_d;
         ptr_q   <= ptr_d;
         wd_q    <= wd_d;
         terr_q  <= terr_d;
      end
   end

   assign busy        = (state_q == BUSY);
   assign m_bgrant    = grant_q;
   assign grant_id    = gid_q;
   assign timeout_err = terr_q;

   // Mux from the registered owner; everything is forced to zero while idle.
   assign bus_addr   = busy ? m_addr[gid_q*ADDR_W +: ADDR_W]  : '0;
   assign bus_wdata  = busy ? m_wdata[gid_q*DATA_W +: DATA_W] : '0;
   assign bus_mode   = busy & m_mode[gid_q];
   assign bus_mvalid = busy & m_valid[gid_q];

   assign m_sl_valid = {NUM_MASTERS{bus_sl_valid}} & grant_q;
   assign m_rdata    = bus_rdata;

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios followed by random traffic,
// compared every cycle against a behavioural model of owner / pointer / silence count.
module tb_bus_arbiter;

   localparam int N  = 3;
   localparam int AW = 16;
   localparam int DW = 8;
   localparam int TO = 4;

   logic            clk;
   logic            rst;
   logic [N-1:0]    m_breq;
   logic [N-1:0]    m_bgrant;
   logic [N*AW-1:0] m_addr;
   logic [N*DW-1:0] m_wdata;
   logic [N-1:0]    m_mode;
   logic [N-1:0]    m_valid;
   logic [N-1:0]    m_sl_valid;
   logic [DW-1:0]   m_rdata;
   logic [AW-1:0]   bus_addr;
   logic [DW-1:0]   bus_wdata;
   logic            bus_mode;
   logic            bus_mvalid;
   logic [DW-1:0]   bus_rdata;
   logic            bus_sl_valid;
   logic [1:0]      grant_id;
   logic            busy;
   logic            timeout_err;

   int n_assert = 0;
   int n_fail   = 0;

   // Reference model: owner index (-1 = nobody), next-start pointer, silent BUSY cycles.
   int owner;
   int ptr_m;
   int silent;
   bit to_m;

   bus_arbiter #(
      .NUM_MASTERS (N),
      .ADDR_W      (AW),
      .DATA_W      (DW),
      .TIMEOUT     (TO)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .m_breq       (m_breq),
      .m_bgrant     (m_bgrant),
      .m_addr       (m_addr),
      .m_wdata      (m_wdata),
      .m_mode       (m_mode),
      .m_valid      (m_valid),
      .m_sl_valid   (m_sl_valid),
      .m_rdata      (m_rdata),
      .bus_addr     (bus_addr),
      .bus_wdata    (bus_wdata),
      .bus_mode     (bus_mode),
      .bus_mvalid   (bus_mvalid),
      .bus_rdata    (bus_rdata),
      .bus_sl_valid (bus_sl_valid),
      .grant_id     (grant_id),
      .busy         (busy),
      .timeout_err  (timeout_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      n_assert++;
      assert (obs === exp_v) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   task automatic model_reset();
      owner  = -1;
      ptr_m  = 0;
      silent = 0;
      to_m   = 1'b0;
   endtask

   // Next-cycle owner from the arbitration rules, using the inputs about to be sampled.
   task automatic model_step();
      int o_n;
      int p_n;
      int s_n;
      bit found;
      o_n   = owner;
      p_n   = ptr_m;
      s_n   = silent;
      to_m  = 1'b0;
      found = 1'b0;
      if (owner < 0) begin
         for (int k = 0; k < N; k++) begin
            if (!found && m_breq[(ptr_m + k) % N]) begin
               found = 1'b1;
               o_n   = (ptr_m + k) % N;
               s_n   = 0;
            end
         end
      end else if (!m_breq[owner]) begin
         o_n = -1;
         p_n = (owner + 1) % N;
      end else if (bus_sl_valid) begin
         s_n = 0;
      end else if (silent + 1 >= TO) begin
         o_n  = -1;
         p_n  = (owner + 1) % N;
         to_m = 1'b1;
      end else begin
         s_n = silent + 1;
      end
      owner  = o_n;
      ptr_m  = p_n;
      silent = s_n;
   endtask

   task automatic check_all(input string tag);
      bit act;
      act = (owner >= 0);
      chk({tag, "/bgrant"}, 32'(m_bgrant), act ? (32'd1 << owner) : 32'd0);
      chk({tag, "/grant_id"}, 32'(grant_id), act ? 32'(owner) : 32'd0);
      chk({tag, "/busy"}, 32'(busy), 32'(act));
      chk({tag, "/timeout_err"}, 32'(timeout_err), 32'(to_m));
      chk({tag, "/bus_addr"}, 32'(bus_addr), act ? 32'(m_addr[owner*AW +: AW]) : 32'd0);
      chk({tag, "/bus_wdata"}, 32'(bus_wdata), act ? 32'(m_wdata[owner*DW +: DW]) : 32'd0);
      chk({tag, "/bus_mode"}, 32'(bus_mode), act ? 32'(m_mode[owner]) : 32'd0);
      chk({tag, "/bus_mvalid"}, 32'(bus_mvalid), act ? 32'(m_valid[owner]) : 32'd0);
      chk({tag, "/m_sl_valid"}, 32'(m_sl_valid),
          (act && bus_sl_valid) ? (32'd1 << owner) : 32'd0);
      chk({tag, "/m_rdata"}, 32'(m_rdata), 32'(bus_rdata));
   endtask

   task automatic tick(input string tag);
      model_step();
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   // Called 1 time unit after a rising edge; reset stays clear of both edges.
   task automatic do_reset();
      rst = 1'b1;
      model_reset();
      #2;
      rst = 1'b0;
      #1;
      check_all("reset");
   endtask

   int exp_ord [4] = '{0, 1, 2, 0};
   int cur;

   initial begin
      rst          = 1'b1;
      m_breq       = '0;
      m_addr       = '0;
      m_wdata      = '0;
      m_mode       = '0;
      m_valid      = '0;
      bus_rdata    = '0;
      bus_sl_valid = 1'b0;
      model_reset();
      #12;
      check_all("por");
      rst = 1'b0;

      // Single master with a full transaction.
      m_breq  = 3'b010;
      m_addr  = {16'hBEEF, 16'h1234, 16'h5555};
      m_wdata = {8'h11, 8'hA5, 8'h22};
      m_mode  = 3'b010;
      m_valid = 3'b010;
      tick("single_req");
      chk("single/bgrant_const", 32'(m_bgrant), 32'h2);
      chk("single/addr_const", 32'(bus_addr), 32'h1234);
      bus_sl_valid = 1'b1;
      bus_rdata    = 8'h3C;
      #1;
      chk("single/slv_const", 32'(m_sl_valid), 32'h2);
      chk("single/rdata_const", 32'(m_rdata), 32'h3C);
      tick("single_resp");
      bus_sl_valid = 1'b0;
      m_breq       = 3'b000;
      tick("single_release");
      tick("single_idle");

      // Asynchronous reset in the middle of a BUSY period.
      m_breq = 3'b001;
      tick("rst_grant");
      #2;
      rst = 1'b1;
      #1;
      chk("rst_mid/bgrant", 32'(m_bgrant), 32'h0);
      chk("rst_mid/busy", 32'(busy), 32'h0);
      chk("rst_mid/bus_addr", 32'(bus_addr), 32'h0);
      model_reset();
      m_breq = 3'b000;
      #2;
      rst = 1'b0;
      tick("rst_after");

      // Round robin with all requests held; each master drops after its response.
      m_breq = 3'b111;
      for (int i = 0; i < 4; i++) begin
         tick("rr_grant");
         chk("rr/order", 32'(grant_id), 32'(exp_ord[i]));
         cur          = int'(grant_id);
         bus_sl_valid = 1'b1;
         tick("rr_resp");
         bus_sl_valid = 1'b0;
         m_breq[cur]  = 1'b0;
         tick("rr_drop");
         chk("rr/idle_gap", 32'(busy), 32'h0);
         m_breq[cur]  = 1'b1;
      end
      m_breq = 3'b000;
      tick("rr_end");
      tick("rr_end2");

      // No preemption: master 0 waits behind owner 2.
      do_reset();
      m_breq = 3'b100;
      tick("np_grant2");
      m_breq       = 3'b101;
      bus_sl_valid = 1'b1;
      tick("np_hold1");
      tick("np_hold2");
      chk("np/owner_kept", 32'(m_bgrant), 32'h4);
      bus_sl_valid = 1'b0;
      m_breq       = 3'b001;
      tick("np_release");
      chk("np/gap", 32'(m_bgrant), 32'h0);
      tick("np_grant0");
      chk("np/grant0_const", 32'(m_bgrant), 32'h1);
      m_breq = 3'b000;
      tick("np_end");
      tick("np_end2");

      // Watchdog reclaims the bus from a silent owner.
      do_reset();
      m_breq = 3'b010;
      tick("wd_grant");
      for (int i = 0; i < TO - 1; i++) begin
         tick("wd_silent");
         chk("wd/still_owned", 32'(m_bgrant), 32'h2);
      end
      tick("wd_fire");
      chk("wd/released", 32'(m_bgrant), 32'h0);
      chk("wd/pulse", 32'(timeout_err), 32'h1);
      m_breq = 3'b111;
      tick("wd_rearb");
      chk("wd/pulse_end", 32'(timeout_err), 32'h0);
      chk("wd/ptr_next", 32'(grant_id), 32'h2);
      m_breq = 3'b000;
      tick("wd_end");
      tick("wd_end2");

      // Stray slave valid while idle.
      bus_sl_valid = 1'b1;
      bus_rdata    = 8'h77;
      #1;
      chk("stray/slv", 32'(m_sl_valid), 32'h0);
      tick("stray1");
      tick("stray2");
      chk("stray/busy", 32'(busy), 32'h0);
      bus_sl_valid = 1'b0;

      // Random traffic against the model.
      for (int c = 0; c < 600; c++) begin
         for (int b = 0; b < N; b++) begin
            if ($urandom_range(0, 3) == 0) begin
               m_breq[b] = ~m_breq[b];
            end
         end
         m_addr       = 48'({$urandom(), $urandom()});
         m_wdata      = 24'($urandom());
         m_mode       = 3'($urandom());
         m_valid      = 3'($urandom());
         bus_rdata    = 8'($urandom());
         bus_sl_valid = ($urandom_range(0, 2) == 0);
         #1;
         check_all("rand_comb");
         tick("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
